// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM states, iteration constants and a small two's-complement helper.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ITER_COUNT   = 32;
  localparam int CNT_W        = $clog2(ITER_COUNT);
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  // Conditional two's-complement negation, used both to take the magnitude
  // of signed operands and to restore the sign of results.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply and restoring
// divide on 32-bit magnitudes. Sign handling lives in the sequencer.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic        load_div,
  input  logic [31:0] mag_a,
  input  logic [31:0] mag_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        div_mode;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] operand;
  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic [31:0] sub_res;
  logic        fits;

  // Per-step arithmetic: the partial-product add and the trial subtraction.
  // The remainder after a successful subtract is below the divisor, so the
  // 32-bit truncated difference is exact.
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    fits    = (shifted >= {1'b0, operand});
    sub_res = shifted[31:0] - operand;
  end

  // Load magnitudes at acceptance, then advance one bit per RUN cycle.
  // Multiply: acc_lo holds the multiplier and shifts out as the product
  // shifts in. Divide: acc_lo holds the dividend and collects quotient bits.
  always_ff @(posedge clk) begin
    if (load) begin
      div_mode <= load_div;
      acc_hi   <= 32'd0;
      acc_lo   <= load_div ? mag_a : mag_b;
      operand  <= load_div ? mag_b : mag_a;
    end else if (step) begin
      if (div_mode) begin
        if (fits) begin
          acc_hi <= sub_res;
          acc_lo <= {acc_lo[30:0], 1'b1};
        end else begin
          acc_hi <= shifted[31:0];
          acc_lo <= {acc_lo[30:0], 1'b0};
        end
      end else begin
        acc_hi <= add_sum[32:1];
        acc_lo <= {add_sum[0], acc_lo[31:1]};
      end
    end
  end

  assign res_hi = acc_hi;
  assign res_lo = acc_lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS-style HI/LO multiply/divide sequencer. Owns the IDLE/RUN/FIX FSM,
// iteration counter, sign handling and the architectural HI/LO registers.
// Optional feature: define MULDIV_FAST_MULT_EN for single-cycle MULT/MULTU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] count;

  logic        is_mult;
  logic        is_div;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic        iter_start;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic        div_mode;
  logic        neg_main;
  logic        neg_rem;
  logic        dbz_pending;
  logic [31:0] a_saved;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [63:0] prod_raw;
  logic [63:0] prod_fixed;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Decode the request and form operand magnitudes for the unsigned core.
  always_comb begin
    is_mult   = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed && a[31];
    b_neg     = is_signed && b[31];
    mag_a     = magnitude(a, a_neg);
    mag_b     = magnitude(b, b_neg);
`ifdef MULDIV_FAST_MULT_EN
    iter_start = start && (state == S_IDLE) && is_div;
`else
    iter_start = start && (state == S_IDLE) && (is_mult || is_div);
`endif
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod;

  // Sign-extending both operands to 64 bits makes the truncated unsigned
  // product equal to the signed product for MULT.
  always_comb begin
    fast_prod = {{32{a_neg}}, a} * {{32{b_neg}}, b};
  end
`endif

  // Remember what the FIX step needs: op class, result signs, divide-by-zero
  // and the raw dividend that HI must return when the divisor is zero.
  always_ff @(posedge clk) begin
    if (iter_start) begin
      div_mode    <= is_div;
      neg_main    <= a_neg ^ b_neg;
      neg_rem     <= a_neg;
      dbz_pending <= is_div && (b == 32'd0);
      a_saved     <= a;
    end
  end

  muldiv_iter_core u_core (
    .clk      (clk),
    .load     (iter_start),
    .step     (state == S_RUN),
    .load_div (is_div),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  // Sign correction and divide-by-zero override applied during FIX.
  always_comb begin
    prod_raw   = {res_hi, res_lo};
    prod_fixed = neg_main ? (~prod_raw + 64'd1) : prod_raw;
    quo        = magnitude(res_lo, neg_main);
    rem        = magnitude(res_hi, neg_rem);
    if (dbz_pending) begin
      fix_hi = a_saved;
      fix_lo = DIV_ZERO_LO;
    end else if (div_mode) begin
      fix_hi = rem;
      fix_lo = quo;
    end else begin
      fix_hi = prod_fixed[63:32];
      fix_lo = prod_fixed[31:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; busy covers every cycle an iterative op is in flight.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: if (iter_start) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (count == CNT_W'(ITER_COUNT - 1)) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Iteration counter: cleared on acceptance, advanced once per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset)                  count <= '0;
    else if (iter_start)        count <= '0;
    else if (state == S_RUN)    count <= count + CNT_W'(1);
  end

  // Architectural HI/LO plus the done/div_by_zero pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == S_FIX) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        done        <= 1'b1;
        div_by_zero <= dbz_pending;
      end else if (start && (state == S_IDLE)) begin
        if (op == OP_MTHI)      hi <= a;
        else if (op == OP_MTLO) lo <= a;
`ifdef MULDIV_FAST_MULT_EN
        else if (is_mult) begin
          hi   <= fast_prod[63:32];
          lo   <= fast_prod[31:0];
          done <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  op request; sampled on rising clk edge.
REQ-005 op  input  3  MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 reserved.
REQ-006 a  input  XLEN  rs operand (dividend/multiplicand); also MTHI/MTLO data.
REQ-007 b  input  XLEN  rt operand (divisor/multiplier).
REQ-008 busy  output  1  high while an iterative op is in flight; pipeline stalls on MFHI/MFLO/new mult-div while high.
REQ-009 done  output  1  one-cycle pulse when hi/lo are updated by a mult/div.
REQ-010 div_by_zero  output  1  valid with done; high if the completed op was DIV/DIVU with b==0.
REQ-011 hi  output  XLEN  architectural HI register.
REQ-012 lo  output  XLEN  architectural LO register.

Function
REQ-013 FSM states IDLE, RUN, FIX; reset state IDLE.
REQ-014 IDLE: start with op 0–3 accepted at edge k, operands latched, sign-magnitude conversion applied, state->RUN, iteration counter=0.
REQ-015 RUN: one bit per cycle (shift-add for mult, restoring subtract for div), 32 cycles, counter 0..31; counter==31 -> FIX.
REQ-016 FIX: sign correction applied, result written to hi/lo at the FIX->IDLE edge.
REQ-017 Latency: busy high cycles k+1..k+33; done high cycle k+34 only, hi/lo already holding the new value in that cycle; busy low in that cycle.
REQ-018 start with op 0–3 accepted in the done cycle (back-to-back).
REQ-019 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of a×b.
REQ-020 DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of a; 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-021 DIVU: lo = a/b, hi = a%b, unsigned.
REQ-022 b==0 (DIV/DIVU): full latency, lo=0xFFFFFFFF, hi=a, div_by_zero=1 with done.
REQ-023 MTHI/MTLO in IDLE: hi (resp. lo) = a at the next edge; no busy, no done.
REQ-024 start while busy (any op) is ignored; no queueing; in-flight op unaffected.
REQ-025 Reserved op codes ignored: no state change.
REQ-026 hi/lo hold their value in all cycles not named above.

Reset
REQ-027 reset, including mid-operation: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0 at the next edge; in-flight op discarded, no done.
REQ-028 reset has priority over start.

Configuration
REQ-029 MULDIV_FAST_MULT_EN defined: MULT/MULTU complete in a single cycle: never enter RUN, busy stays low, hi/lo updated at edge k, done high cycle k+1; DIV/DIVU unchanged.
REQ-030 MULDIV_FAST_MULT_EN undefined: all four ops use the iterative 34-cycle path of REQ-017.

Structure
REQ-031 Package muldiv_pkg holds: op-code enum, FSM state enum, XLEN default, iteration count constant 32, div-by-zero lo constant.
REQ-032 Sub-module muldiv_iter_core holds the one-bit-per-cycle shift/add/subtract datapath; muldiv_sequencer owns the FSM, counter, sign handling, and HI/LO.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at k+34, hi=0xFFFFFFFE, lo=0x00000001, busy high k+1..k+33.
REQ-034 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU a=100 b=0 -> done at k+34, div_by_zero=1, lo=0xFFFFFFFF, hi=100.
REQ-036 DIV started, MTHI a=0x1234 asserted during busy, reset asserted at k+10 -> no done, hi=lo=0, busy=0 at k+11; MTHI 0x1234 in IDLE -> hi=0x1234 next cycle.
REQ-037 Back-to-back: DIVU 0x80000000/0x10 accepted in done cycle of prior MULTU -> second done 34 cycles later, lo=0x08000000, hi=0.
REQ-038 With MULDIV_FAST_MULT_EN: MULT 6×7 -> busy never high, done cycle k+1, hi=0, lo=42.
